// File: rtl/pattern_pkg.sv
// pattern_pkg: shared state type, default sizes and width helpers.
// The readback option is selected by PATBUF_READBACK_EN in pattern_banks.
package pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_SWAP
  } state_t;

  localparam int NUM_BUFS_DEF  = 8;
  localparam int BUF_DEPTH_DEF = 32;
  localparam int BUF_WIDTH_DEF = 6;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sel_w(input int n);
    return idx_w(n);
  endfunction

  function automatic int fld_w(input int n);
    return idx_w(n);
  endfunction

endpackage

// File: rtl/pattern_serial_rx.sv
// pattern_serial_rx: synchronises the serial port and assembles words.
// sclk_fall exists only when PATBUF_READBACK_EN is defined.
module pattern_serial_rx
  import pattern_pkg::*;
#(
  parameter int W = BUF_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         sin,
  input  logic         ssel,
  input  logic         shift_en,
`ifdef PATBUF_READBACK_EN
  output logic         sclk_fall,
`endif
  output logic         frame_start,
  output logic         frame_end,
  output logic         word_valid,
  output logic [W-1:0] word
);

  localparam int CW = idx_w(W);

  logic [2:0]    sclk_q;
  logic [1:0]    sin_q;
  logic [2:0]    ssel_q;
  logic [CW-1:0] cnt_q;
  logic          sclk_rise;

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign frame_start = ssel_q[1] & ~ssel_q[2];
  assign frame_end   = ~ssel_q[1] & ssel_q[2];
`ifdef PATBUF_READBACK_EN
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
`endif

  // two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      sin_q  <= '0;
      ssel_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      sin_q  <= {sin_q[0], sin};
      ssel_q <= {ssel_q[1:0], ssel};
    end
  end

  // shift MSB-first bits in and flag each completed word for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (frame_start) begin
        cnt_q <= '0;
      end else if (shift_en && sclk_rise) begin
        word <= {word[W-2:0], sin_q[1]};
        if (cnt_q == CW'(W - 1)) begin
          cnt_q      <= '0;
          word_valid <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pattern_banks.sv
// pattern_banks: double-buffered pattern store with serial shadow loading.
// Define PATBUF_READBACK_EN to build the serial readback of shadow words.
module pattern_banks
  import pattern_pkg::*;
#(
  parameter  int NUM_BUFS  = NUM_BUFS_DEF,
  parameter  int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter  int BUF_WIDTH = BUF_WIDTH_DEF,
  localparam int SEL_W     = sel_w(NUM_BUFS),
  localparam int FLD_W     = fld_w(BUF_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sclk,
  input  logic                           sin,
  input  logic                           ssel,
  input  logic [SEL_W-1:0]               saddr,
  output logic                           sout,
  input  logic [SEL_W-1:0]               buf_sel,
  output logic [BUF_DEPTH*BUF_WIDTH-1:0] pattern_out,
  input  logic [FLD_W-1:0]               field_rd_addr,
  output logic [BUF_WIDTH-1:0]           field_rd_data,
  input  logic                           field_wr_en,
  input  logic [FLD_W-1:0]               field_wr_addr,
  input  logic [BUF_WIDTH-1:0]           field_wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack
);

  state_t               state, state_nxt;
  logic [BUF_WIDTH-1:0] act_q [NUM_BUFS][BUF_DEPTH];
  logic [BUF_WIDTH-1:0] shd_q [NUM_BUFS][BUF_DEPTH];
  logic [BUF_WIDTH-1:0] src   [BUF_DEPTH];
  logic [NUM_BUFS-1:0]  dirty_q;
  logic [SEL_W-1:0]     saddr_q;
  logic [FLD_W-1:0]     wptr_q;
  logic [BUF_WIDTH-1:0] word;
  logic [BUF_DEPTH*BUF_WIDTH-1:0] pat_nxt;
  logic frame_start, frame_end, word_valid;
  logic enter, swapping, shifting;
  logic sel_ok, rd_ok, wr_ok, tgt_ok;
`ifdef PATBUF_READBACK_EN
  logic sclk_fall;
`endif

  assign swapping = (state == S_SWAP);
  assign shifting = (state == S_SHIFT);
  assign sel_ok   = int'(buf_sel) < NUM_BUFS;
  assign rd_ok    = int'(field_rd_addr) < BUF_DEPTH;
  assign wr_ok    = sel_ok && (int'(field_wr_addr) < BUF_DEPTH);
  assign tgt_ok   = int'(saddr_q) < NUM_BUFS;

  pattern_serial_rx #(.W(BUF_WIDTH)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .sin         (sin),
    .ssel        (ssel),
    .shift_en    (shifting),
`ifdef PATBUF_READBACK_EN
    .sclk_fall   (sclk_fall),
`endif
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .word_valid  (word_valid),
    .word        (word)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // frames take priority; a request is not re-taken while ack is showing
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_SHIFT;
          enter     = 1'b1;
        end else if (swap_req && !swap_ack) begin
          state_nxt = S_SWAP;
        end
      end
      S_SHIFT: if (frame_end) state_nxt = S_IDLE;
      S_SWAP: begin
        state_nxt = S_IDLE;
        if (frame_start) begin
          state_nxt = S_SHIFT;
          enter     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // storage: shadow loads, field writes, then the swap so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q  <= '0;
      saddr_q  <= '0;
      wptr_q   <= '0;
      swap_ack <= 1'b0;
      for (int b = 0; b < NUM_BUFS; b++) begin
        for (int f = 0; f < BUF_DEPTH; f++) begin
          act_q[b][f] <= '0;
          shd_q[b][f] <= '0;
        end
      end
    end else begin
      swap_ack <= swapping;
      if (enter) begin
        saddr_q <= saddr;
        wptr_q  <= '0;
      end
      if (word_valid && shifting) begin
        if (tgt_ok) begin
          shd_q[saddr_q][wptr_q] <= word;
          dirty_q[saddr_q]       <= 1'b1;
        end
        if (wptr_q == FLD_W'(BUF_DEPTH - 1)) wptr_q <= '0;
        else wptr_q <= wptr_q + FLD_W'(1);
      end
      if (field_wr_en && wr_ok)
        act_q[buf_sel][field_wr_addr] <= field_wr_data;
      if (swapping) begin
        for (int b = 0; b < NUM_BUFS; b++)
          if (dirty_q[b]) act_q[b] <= shd_q[b];
        dirty_q <= '0;
      end
    end
  end

  // read source forwards the swap so it shows together with swap_ack
  always_comb begin
    src = act_q[buf_sel];
    if (swapping && dirty_q[buf_sel]) src = shd_q[buf_sel];
    pat_nxt = '0;
    for (int f = 0; f < BUF_DEPTH; f++)
      pat_nxt[f*BUF_WIDTH +: BUF_WIDTH] = src[f];
  end

  // registered engine-side read ports
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_out   <= '0;
      field_rd_data <= '0;
    end else begin
      pattern_out   <= sel_ok ? pat_nxt : '0;
      field_rd_data <= (sel_ok && rd_ok) ? src[field_rd_addr] : '0;
    end
  end

`ifdef PATBUF_READBACK_EN
  logic [BUF_WIDTH-1:0] rb_q;
  logic                 rb_reload;

  // old shadow word shifts out; next word loads on the fall after a word
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_q      <= '0;
      rb_reload <= 1'b0;
    end else if (enter) begin
      rb_q      <= (int'(saddr) < NUM_BUFS) ? shd_q[saddr][0] : '0;
      rb_reload <= 1'b0;
    end else if (shifting) begin
      if (word_valid) rb_reload <= 1'b1;
      if (sclk_fall) begin
        if (rb_reload) begin
          rb_q      <= tgt_ok ? shd_q[saddr_q][wptr_q] : '0;
          rb_reload <= 1'b0;
        end else begin
          rb_q <= rb_q << 1;
        end
      end
    end
  end

  assign sout = shifting & rb_q[BUF_WIDTH-1];
`else
  assign sout = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_banks.sv
// tb_pattern_banks: directed, table-driven and random checks of pattern_banks.
// Reference model keeps active/shadow contents as plain arrays.
module tb_pattern_banks;

  logic         clk, rst, sclk, sin, ssel, sout;
  logic [2:0]   saddr, buf_sel;
  logic [191:0] pattern_out;
  logic [4:0]   field_rd_addr, field_wr_addr;
  logic [5:0]   field_rd_data, field_wr_data;
  logic         field_wr_en, swap_req, swap_ack;

  int n_chk  = 0;
  int n_pass = 0;
  int ack_cnt = 0;

  logic [5:0] m_act [8][32];
  logic [5:0] m_shd [8][32];
  bit         m_dirty [8];
  int         m_b, m_wp;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] ra;
    logic       we;
    logic [4:0] wa;
    logic [5:0] wd;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [8];

  pattern_banks dut (
    .clk           (clk),
    .rst           (rst),
    .sclk          (sclk),
    .sin           (sin),
    .ssel          (ssel),
    .saddr         (saddr),
    .sout          (sout),
    .buf_sel       (buf_sel),
    .pattern_out   (pattern_out),
    .field_rd_addr (field_rd_addr),
    .field_rd_data (field_rd_data),
    .field_wr_en   (field_wr_en),
    .field_wr_addr (field_wr_addr),
    .field_wr_data (field_wr_data),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (swap_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [191:0] got,
                       input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [191:0] pack(input int b);
    logic [191:0] r;
    r = '0;
    for (int f = 0; f < 32; f++) r[f*6 +: 6] = m_act[b][f];
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      m_dirty[b] = 0;
      for (int f = 0; f < 32; f++) begin
        m_act[b][f] = '0;
        m_shd[b][f] = '0;
      end
    end
  endtask

  task automatic model_swap();
    for (int b = 0; b < 8; b++) begin
      if (m_dirty[b])
        for (int f = 0; f < 32; f++) m_act[b][f] = m_shd[b][f];
      m_dirty[b] = 0;
    end
  endtask

  task automatic send_bit(input logic b, output logic so);
    sin = b;
    repeat (4) step();
    so = sout;
    sclk = 1'b1;
    repeat (4) step();
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [5:0] w, output logic [5:0] so);
    for (int i = 5; i >= 0; i--) send_bit(w[i], so[i]);
    m_shd[m_b][m_wp] = w;
    m_dirty[m_b] = 1;
    m_wp = (m_wp + 1) % 32;
  endtask

  task automatic start_frame(input int b);
    saddr = 3'(b);
    m_b = b;
    m_wp = 0;
    ssel = 1'b1;
    repeat (6) step();
  endtask

  task automatic end_frame();
    repeat (6) step();
    ssel = 1'b0;
    repeat (6) step();
  endtask

  task automatic wait_ack();
    int lat;
    lat = 0;
    while (swap_ack !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    swap_req = 1'b0;
    check("swap_ack seen", swap_ack, 1);
    if (swap_ack === 1'b1) begin
      model_swap();
      check("pattern_out at ack", pattern_out, pack(buf_sel));
    end
  endtask

  task automatic do_swap();
    int lat;
    swap_req = 1'b1;
    lat = 0;
    while (swap_ack !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check("swap latency", lat, 2);
    wait_ack();
    step();
  endtask

  task automatic read_field(input int b, input int a, input string nm);
    buf_sel = 3'(b);
    field_rd_addr = 5'(a);
    step();
    check(nm, field_rd_data, m_act[b][a]);
  endtask

  initial begin
    logic [5:0] so, rb_exp;
    int a0;
    rst = 1'b1; sclk = 0; sin = 0; ssel = 0; saddr = 0; buf_sel = 0;
    field_rd_addr = 0; field_wr_addr = 0; field_wr_data = 0;
    field_wr_en = 0; swap_req = 0;
    model_reset();
    repeat (3) step();
    check("reset pattern_out", pattern_out, 0);
    check("reset field_rd_data", field_rd_data, 0);
    check("reset swap_ack", swap_ack, 0);
    check("reset sout", sout, 0);
    rst = 1'b0;
    step();

    // buffer 2 <- 0..31, read before and after commit
    start_frame(2);
    for (int k = 0; k < 32; k++) send_word(6'(k), so);
    end_frame();
    buf_sel = 3'd2;
    field_rd_addr = 5'd5;
    step();
    check("pre-swap rd", field_rd_data, 0);
    a0 = ack_cnt;
    do_swap();
    repeat (4) step();
    check("single ack", ack_cnt - a0, 1);
    check("buf2 field 9", pattern_out[9*6 +: 6], 6'h09);

    // field port table
    tbl[0] = '{sel:3'd2, ra:5'd5,  we:1'b0, wa:5'd0, wd:6'h00, exp:6'h05};
    tbl[1] = '{sel:3'd2, ra:5'd5,  we:1'b1, wa:5'd5, wd:6'h3F, exp:6'h05};
    tbl[2] = '{sel:3'd2, ra:5'd5,  we:1'b0, wa:5'd0, wd:6'h00, exp:6'h3F};
    tbl[3] = '{sel:3'd3, ra:5'd5,  we:1'b0, wa:5'd0, wd:6'h00, exp:6'h00};
    tbl[4] = '{sel:3'd2, ra:5'd31, we:1'b0, wa:5'd0, wd:6'h00, exp:6'h1F};
    tbl[5] = '{sel:3'd3, ra:5'd0,  we:1'b1, wa:5'd0, wd:6'h15, exp:6'h00};
    tbl[6] = '{sel:3'd3, ra:5'd0,  we:1'b0, wa:5'd0, wd:6'h00, exp:6'h15};
    tbl[7] = '{sel:3'd2, ra:5'd0,  we:1'b0, wa:5'd0, wd:6'h00, exp:6'h00};
    for (int i = 0; i < 8; i++) begin
      buf_sel = tbl[i].sel;
      field_rd_addr = tbl[i].ra;
      field_wr_en = tbl[i].we;
      field_wr_addr = tbl[i].wa;
      field_wr_data = tbl[i].wd;
      step();
      field_wr_en = 1'b0;
      check($sformatf("table[%0d]", i), field_rd_data, tbl[i].exp);
      if (tbl[i].we) m_act[tbl[i].sel][tbl[i].wa] = tbl[i].wd;
    end

    // 33 words wrap onto field 0, then a partial word is dropped
    start_frame(4);
    for (int k = 0; k < 32; k++) send_word(6'((k * 5 + 1) & 63), so);
    send_word(6'h2A, so);
    for (int i = 0; i < 4; i++) send_bit(1'b1, so[0]);
    end_frame();
    buf_sel = 3'd4;
    do_swap();
    read_field(4, 0, "wrap field 0");
    check("wrap field 0 value", field_rd_data, 6'h2A);
    read_field(4, 1, "partial word dropped");

    // readback of the old shadow word while loading a new one
`ifdef PATBUF_READBACK_EN
    rb_exp = 6'h2A;
`else
    rb_exp = 6'h00;
`endif
    start_frame(4);
    send_word(6'h15, so);
    end_frame();
    check("sout readback", so, rb_exp);

    // swap requested mid-frame waits for the frame end
    start_frame(2);
    send_word(6'h11, so);
    end_frame();
    start_frame(5);
    send_word(6'h21, so);
    send_word(6'h22, so);
    a0 = ack_cnt;
    swap_req = 1'b1;
    send_word(6'h23, so);
    repeat (6) step();
    check("no ack mid-frame", ack_cnt - a0, 0);
    ssel = 1'b0;
    wait_ack();
    repeat (5) step();
    check("one ack after frame", ack_cnt - a0, 1);
    read_field(2, 0, "buf2 committed");
    read_field(5, 2, "buf5 committed");
    read_field(4, 0, "buf4 committed");

    // field write in the swap cycle loses to the dirty shadow
    start_frame(6);
    for (int k = 9; k < 13; k++) send_word(6'(k), so);
    end_frame();
    swap_req = 1'b1;
    step();
    buf_sel = 3'd6;
    field_wr_en = 1'b1;
    field_wr_addr = 5'd3;
    field_wr_data = 6'h33;
    step();
    field_wr_en = 1'b0;
    swap_req = 1'b0;
    check("ack in swap-write seq", swap_ack, 1);
    model_swap();
    check("pattern_out swap-write", pattern_out, pack(6));
    step();
    read_field(6, 3, "swap beats write");
    check("swap beats write value", field_rd_data, 6'h0C);

    // reset in the middle of a frame
    buf_sel = 3'd2;
    step();
    start_frame(1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, so[0]);
    rst = 1'b1; ssel = 0; sclk = 0; sin = 0;
    step();
    check("rst pattern_out", pattern_out, 0);
    check("rst field_rd_data", field_rd_data, 0);
    check("rst swap_ack", swap_ack, 0);
    check("rst sout", sout, 0);
    step();
    rst = 1'b0;
    model_reset();
    step();
    start_frame(1);
    send_word(6'h21, so);
    send_word(6'h12, so);
    end_frame();
    buf_sel = 3'd1;
    do_swap();
    read_field(1, 0, "post-rst field 0");
    read_field(1, 1, "post-rst field 1");

    // random traffic against the model
    for (int it = 0; it < 150; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        int n;
        start_frame(int'($urandom_range(0, 7)));
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++) send_word(6'($urandom), so);
        end_frame();
      end else if (op == 1) begin
        do_swap();
      end else begin
        logic [5:0] exp_rd;
        logic [191:0] exp_pat;
        buf_sel = 3'($urandom);
        field_rd_addr = 5'($urandom);
        field_wr_en = 1'($urandom);
        field_wr_addr = 5'($urandom);
        field_wr_data = 6'($urandom);
        exp_rd = m_act[buf_sel][field_rd_addr];
        exp_pat = pack(buf_sel);
        step();
        check("rand field_rd_data", field_rd_data, exp_rd);
        check("rand pattern_out", pattern_out, exp_pat);
        if (field_wr_en) m_act[buf_sel][field_wr_addr] = field_wr_data;
        field_wr_en = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
